fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned DEPTH_DEFAULT    = 2;
    localparam int unsigned XLEN             = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {instr, pc}; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, redirect flush, small decode buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occ_after;
    fetch_entry_t     head;

    // A redirect discards whatever decode would have taken this cycle.
    assign pop = instr_valid & instr_ready & ~redirect;

    // Issue gating treats the request in flight as an occupied slot.
    always_comb begin
        issue     = 1'b0;
        push      = 1'b0;
        occ_after = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
        if (rst_n && !redirect) begin
            case (state)
                ST_IDLE: issue = (count < CNT_W'(DEPTH));
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        push  = 1'b1;
                        issue = (occ_after < (CNT_W+1)'(DEPTH));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_target & ~32'h3;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (issue) begin
                req_pc <= fetch_pc;
            end
            case (state)
                ST_IDLE: if (issue) state <= ST_WAIT;
                ST_WAIT: begin
                    if (redirect) begin
                        state <= imem_rvalid ? ST_IDLE : ST_DROP;
                    end else if (imem_rvalid) begin
                        state <= issue ? ST_WAIT : ST_IDLE;
                    end
                end
                ST_DROP: if (imem_rvalid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ('{instr: imem_rdata, pc: req_pc}),
        .rdata (head),
        .count (count)
    );

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios, expected requests/instructions queued.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];
    int unsigned mem_lat = 1;
    logic        inj_rv = 1'b0;

    localparam logic [31:0] INJ_DATA = 32'hDEAD_BEEF;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Hold reset two cycles, check reset outputs, release so the caller is in cycle 1.
    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        inj_rv   = 1'b0;
        step();
        at_neg();
        check1("reset_imem_req", imem_req, 1'b0);
        check1("reset_instr_valid", instr_valid, 1'b0);
        check32("reset_instr", instr, 32'h0);
        check32("reset_instr_pc", instr_pc, 32'h0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic end_scn();
        check32("pending_addr", 32'(exp_addr.size()), 32'd0);
        check32("pending_instr", 32'(exp_pc.size()), 32'd0);
    endtask

    // Memory model: answers each request mem_lat cycles later; inj_rv forces a stray strobe.
    initial begin : memory
        logic        pend;
        logic [31:0] paddr;
        int unsigned cnt;
        pend = 1'b0;
        paddr = '0;
        cnt = 0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend && cnt == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_at(paddr);
                pend        = 1'b0;
            end else begin
                imem_rvalid = inj_rv;
                imem_rdata  = inj_rv ? INJ_DATA : '0;
                if (pend) cnt--;
            end
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else if (imem_req) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = mem_lat;
            end
        end
    end

    initial begin : monitor
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req) begin
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL imem_addr: got request to %h expected none", imem_addr);
                end else begin
                    check32("imem_addr", imem_addr, exp_addr.pop_front());
                end
            end
            if (rst_n && instr_valid && instr_ready && !redirect) begin
                if (exp_pc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL consume: got instr_pc %h expected none", instr_pc);
                end else begin
                    p = exp_pc.pop_front();
                    check32("consume_pc", instr_pc, p);
                    check32("consume_instr", instr, word_at(p));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100us");
        $fatal(1, "timeout");
    end

    initial begin : main
        // Streaming with ready=1, then stall with head at pc 8.
        instr_ready = 1'b1;
        mem_lat = 1;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
        exp_pc.push_back(32'h0); exp_pc.push_back(32'h4);
        do_reset();
        at_neg(); check1("a_c1_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("a_c2_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("a_c3_valid", instr_valid, 1'b1); check32("a_c3_pc", instr_pc, 32'h0);
        step(); at_neg(); check32("a_c4_pc", instr_pc, 32'h4);
        step(); instr_ready = 1'b0; at_neg(); check32("a_c5_pc", instr_pc, 32'h8);
        for (int i = 0; i < 5; i++) begin
            step(); at_neg();
            check32("a_hold_pc", instr_pc, 32'h8);
            check1("a_hold_req", imem_req, 1'b0);
        end
        step(); end_scn();

        // Six-cycle stall from reset, then redirect to the top of the address space.
        instr_ready = 1'b0;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        do_reset();
        at_neg();
        step(); at_neg();
        step(); at_neg(); check1("b_c3_valid", instr_valid, 1'b1); check32("b_c3_pc", instr_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(); at_neg();
            check32("b_hold_pc", instr_pc, 32'h0);
            check32("b_hold_instr", instr, word_at(32'h0));
            check1("b_full_req", imem_req, 1'b0);
        end
        step(); redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0);
        at_neg(); check1("e_redir_req", imem_req, 1'b0);
        step(); redirect = 1'b0; at_neg(); check1("e_flush_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("e_lat2_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("e_lat3_valid", instr_valid, 1'b1); check32("e_lat3_pc", instr_pc, 32'hFFFF_FFFC);
        step(); at_neg(); check32("e_hold_pc", instr_pc, 32'hFFFF_FFFC); check1("e_full_req", imem_req, 1'b0);
        step(); end_scn();

        // Redirect while waiting; the stale response arrives a cycle later and is dropped.
        instr_ready = 1'b1;
        mem_lat = 1;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104); exp_addr.push_back(32'h108);
        exp_pc.push_back(32'h100);
        do_reset();
        at_neg();
        step(); mem_lat = 2; at_neg(); check1("c_c2_valid", instr_valid, 1'b0);
        step(); redirect = 1'b1; redirect_target = 32'h100;
        at_neg(); check1("c_c3_valid", instr_valid, 1'b1); check1("c_c3_req", imem_req, 1'b0);
        step(); redirect = 1'b0; mem_lat = 1;
        at_neg(); check1("c_drop_valid", instr_valid, 1'b0); check1("c_drop_req", imem_req, 1'b0);
        step(); at_neg(); check1("c_c5_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("c_c6_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("c_c7_valid", instr_valid, 1'b1); check32("c_c7_pc", instr_pc, 32'h100);
        step(); instr_ready = 1'b0; at_neg(); check32("c_c8_pc", instr_pc, 32'h104);
        step(); at_neg(); check1("c_full_req", imem_req, 1'b0);
        step(); end_scn();

        // Unaligned redirect coincident with a response.
        instr_ready = 1'b0;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h200); exp_addr.push_back(32'h204);
        do_reset();
        at_neg();
        step(); redirect = 1'b1; redirect_target = 32'h203;
        at_neg(); check1("d_redir_req", imem_req, 1'b0);
        step(); redirect = 1'b0; at_neg(); check1("d_empty_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("d_c4_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("d_c5_valid", instr_valid, 1'b1); check32("d_c5_pc", instr_pc, 32'h200);
        step(); at_neg(); check1("d_full_req", imem_req, 1'b0);
        step(); end_scn();

        // Reset while waiting; a stray response in the first cycle after release is ignored.
        instr_ready = 1'b0;
        mem_lat = 2;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        do_reset();
        at_neg();
        step(); rst_n = 1'b0; inj_rv = 1'b1;
        at_neg(); check1("f_rst_req", imem_req, 1'b0); check1("f_rst_valid", instr_valid, 1'b0);
        step(); rst_n = 1'b1; inj_rv = 1'b0; mem_lat = 1;
        at_neg(); check1("f_c3_valid", instr_valid, 1'b0);
        step(); at_neg(); check1("f_ignored_valid", instr_valid, 1'b0);
        step(); at_neg();
        check1("f_c5_valid", instr_valid, 1'b1);
        check32("f_c5_pc", instr_pc, 32'h0);
        check32("f_c5_instr", instr, word_at(32'h0));
        step(); at_neg(); check1("f_full_req", imem_req, 1'b0);
        step(); end_scn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
